// File: rtl/cache_pkg.sv
// Shared definitions for the cache/main-memory arbiter: block geometry,
// memory latency, arbiter state encodings and the block-address helper.
package cache_pkg;

  localparam int WORDS   = 8;
  localparam int LATENCY = 4;

  localparam logic [2:0] ST_DRAIN  = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_FILL_I = 3'd3;
  localparam logic [2:0] ST_FILL_D = 3'd4;

  // Byte address of the first word of the 16-byte block containing addr.
  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return addr & 16'hFFF0;
  endfunction

endpackage

// File: rtl/arb_fill_seq.sv
// Block-fill sequencer: issues WORDS consecutive reads, counts returning
// words and flags the final one.
module arb_fill_seq
  import cache_pkg::*;
#(
  parameter int WORDS = cache_pkg::WORDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mem_data_valid,
  output logic       issue_active,
  output logic [2:0] issue_cnt,
  output logic [2:0] ret_cnt,
  output logic       last_word
);

  localparam logic [2:0] LAST = 3'(WORDS - 1);

  logic       issue_active_q, issue_active_d;
  logic [2:0] issue_cnt_q, issue_cnt_d;
  logic [2:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    issue_active_d = issue_active_q;
    issue_cnt_d    = issue_cnt_q;
    ret_cnt_d      = ret_cnt_q;
    if (start) begin
      issue_active_d = 1'b1;
      issue_cnt_d    = 3'd0;
      ret_cnt_d      = 3'd0;
    end else begin
      if (issue_active_q) begin
        issue_cnt_d = issue_cnt_q + 3'd1;
        if (issue_cnt_q == LAST) issue_active_d = 1'b0;
      end
      if (mem_data_valid) ret_cnt_d = ret_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_active_q <= 1'b0;
      issue_cnt_q    <= 3'd0;
      ret_cnt_q      <= 3'd0;
    end else begin
      issue_active_q <= issue_active_d;
      issue_cnt_q    <= issue_cnt_d;
      ret_cnt_q      <= ret_cnt_d;
    end
  end

  assign issue_active = issue_active_q;
  assign issue_cnt    = issue_cnt_q;
  assign ret_cnt      = ret_cnt_q;
  assign last_word    = mem_data_valid && (ret_cnt_q == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-fill, D-fill and D write-through traffic onto one pipelined
// main memory, returning tagged fill words to the requesting cache.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int LATENCY = cache_pkg::LATENCY,
  parameter int WORDS   = cache_pkg::WORDS,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              i_fill_valid,
  output logic [2:0]        i_fill_word,
  output logic [15:0]       i_fill_data,
  output logic              i_done,
  output logic              i_stall,
  output logic              d_fill_valid,
  output logic [2:0]        d_fill_word,
  output logic [15:0]       d_fill_data,
  output logic              d_done,
  output logic              d_wr_ack,
  output logic              d_stall,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_data_out,
  input  logic              mem_data_valid
);

  localparam int DRN_W = $clog2(LATENCY + 1);

  logic [2:0]        state_q, state_d;
  logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic              last_fill_q, last_fill_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic              start;
  logic              st_fill_i, st_fill_d, st_write;
  logic              fill_vld;
  logic              issue_active, last_word;
  logic [2:0]        issue_cnt, ret_cnt;

  assign st_fill_i = (state_q == ST_FILL_I);
  assign st_fill_d = (state_q == ST_FILL_D);
  assign st_write  = (state_q == ST_WRITE);
  // Read data arriving outside a fill is stale pipeline content.
  assign fill_vld  = mem_data_valid && (st_fill_i || st_fill_d);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    last_fill_d = last_fill_q;
    fill_base_d = fill_base_q;
    start       = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        if (drain_cnt_q <= DRN_W'(1)) state_d = ST_IDLE;
        else drain_cnt_d = drain_cnt_q - DRN_W'(1);
      end
      ST_IDLE: begin
        if (d_req && d_wr) begin
          state_d = ST_WRITE;
        end else if (d_req && (!i_req || last_fill_q)) begin
          state_d     = ST_FILL_D;
          fill_base_d = block_base(d_addr);
          start       = 1'b1;
        end else if (i_req) begin
          state_d     = ST_FILL_I;
          fill_base_d = block_base(i_addr);
          start       = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_FILL_I, ST_FILL_D: begin
        if (last_word) begin
          state_d     = ST_IDLE;
          last_fill_d = st_fill_i;
        end
      end
      default: begin
        state_d     = ST_DRAIN;
        drain_cnt_d = DRN_W'(LATENCY);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DRAIN;
      drain_cnt_q <= DRN_W'(LATENCY);
      last_fill_q <= 1'b0;
      fill_base_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      last_fill_q <= last_fill_d;
      fill_base_q <= fill_base_d;
    end
  end

  arb_fill_seq #(.WORDS(WORDS)) u_seq (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_data_valid (fill_vld),
    .issue_active   (issue_active),
    .issue_cnt      (issue_cnt),
    .ret_cnt        (ret_cnt),
    .last_word      (last_word)
  );

  always_comb begin
    i_fill_valid = st_fill_i && mem_data_valid;
    i_fill_word  = st_fill_i ? ret_cnt : 3'd0;
    i_fill_data  = st_fill_i ? mem_data_out : 16'd0;
    i_done       = st_fill_i && last_word;
    d_fill_valid = st_fill_d && mem_data_valid;
    d_fill_word  = st_fill_d ? ret_cnt : 3'd0;
    d_fill_data  = st_fill_d ? mem_data_out : 16'd0;
    d_done       = st_fill_d && last_word;
    d_wr_ack     = st_write;
    i_stall      = i_req && !i_done;
    d_stall      = d_req && !(d_done || d_wr_ack);
    mem_enable   = st_write || issue_active;
    mem_wr       = st_write;
    mem_wdata    = st_write ? d_wdata : 16'd0;
    mem_addr     = '0;
    if (st_write) mem_addr = d_addr;
    else if (issue_active) mem_addr = fill_base_q | {{(ADDR_W-4){1'b0}}, issue_cnt, 1'b0};
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle pipelined memory model.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_fill_valid, i_done, i_stall;
  logic [2:0]  i_fill_word, d_fill_word;
  logic [15:0] i_fill_data, d_fill_data;
  logic        d_fill_valid, d_done, d_wr_ack, d_stall;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_data_out;
  logic        mem_data_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_fill_valid(i_fill_valid), .i_fill_word(i_fill_word), .i_fill_data(i_fill_data),
    .i_done(i_done), .i_stall(i_stall),
    .d_fill_valid(d_fill_valid), .d_fill_word(d_fill_word), .d_fill_data(d_fill_data),
    .d_done(d_done), .d_wr_ack(d_wr_ack), .d_stall(d_stall),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );

  // Memory model: reads return addr ^ 16'h5A5A four cycles after enable.
  // It has no reset, so reads in flight at a DUT reset still come back.
  logic [3:0]  pv = 4'd0;
  logic [63:0] pa = 64'd0;
  always @(posedge clk) begin
    pv <= {pv[2:0], mem_enable & ~mem_wr};
    pa <= {pa[47:0], mem_addr};
  end
  assign mem_data_valid = pv[3];
  assign mem_data_out   = pv[3] ? (pa[63:48] ^ 16'h5A5A) : 16'h0000;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_en", 16'(mem_enable), 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_ivld", 16'(i_fill_valid), 16'd0);
    chk("rst_ack", 16'(d_wr_ack), 16'd0);
    chk("rst_done", 16'({i_done, d_done}), 16'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("drain_en", 16'(mem_enable), 16'd0);
    end
    cyc();
    chk("idle_en", 16'(mem_enable), 16'd0);
  endtask

  // Starts in an IDLE cycle where the request is visible; ends in the done cycle.
  task automatic fill_run(input bit is_i, input logic [15:0] addr, input int drop_at, input int wr_at);
    logic [15:0] base, wa;
    logic        gv, gd, ov, od, gs;
    logic [2:0]  gw;
    logic [15:0] gdat, odat;
    base = addr & 16'hFFF0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      gv   = is_i ? i_fill_valid : d_fill_valid;
      gd   = is_i ? i_done : d_done;
      gw   = is_i ? i_fill_word : d_fill_word;
      gdat = is_i ? i_fill_data : d_fill_data;
      gs   = is_i ? i_stall : d_stall;
      ov   = is_i ? d_fill_valid : i_fill_valid;
      od   = is_i ? d_done : i_done;
      odat = is_i ? d_fill_data : i_fill_data;
      if (c < 8) begin
        chk("iss_en", 16'(mem_enable), 16'd1);
        chk("iss_addr", mem_addr, base + 16'(2 * c));
      end else begin
        chk("iss_off", 16'(mem_enable), 16'd0);
      end
      chk("fill_nowr", 16'(mem_wr), 16'd0);
      chk("fill_noack", 16'(d_wr_ack), 16'd0);
      chk("other_side", 16'({ov, od}), 16'd0);
      chk("other_data", odat, 16'h0000);
      if (c >= 4) begin
        wa = base + 16'(2 * (c - 4));
        chk("ret_vld", 16'(gv), 16'd1);
        chk("ret_word", 16'(gw), 16'(c - 4));
        chk("ret_data", gdat, wa ^ 16'h5A5A);
      end else begin
        chk("ret_none", 16'(gv), 16'd0);
      end
      chk("done", 16'(gd), (c == 11) ? 16'd1 : 16'd0);
      chk("stall", 16'(gs), (c < 11 && c <= drop_at) ? 16'd1 : 16'd0);
      if (c == drop_at) begin
        if (is_i) i_req = 1'b0;
        else d_req = 1'b0;
      end
      if (c == wr_at) begin
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0080; d_wdata = 16'h1234;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b1; i_addr = 16'h1234;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;

    // Single I fill straight out of reset.
    apply_reset();
    chk("idle_istall", 16'(i_stall), 16'd1);
    fill_run(1'b1, 16'h1234, 11, -1);

    // Write-through from IDLE.
    cyc();
    chk("post_fill_en", 16'(mem_enable), 16'd0);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    #1 chk("wr_dstall", 16'(d_stall), 16'd1);
    cyc();
    chk("wr_en", 16'({mem_enable, mem_wr}), 16'd3);
    chk("wr_addr", mem_addr, 16'h0040);
    chk("wr_data", mem_wdata, 16'hBEEF);
    chk("wr_ack", 16'({d_wr_ack, d_stall}), 16'd2);
    d_req = 1'b0; d_wr = 1'b0;
    cyc();
    chk("wr_once", 16'({mem_enable, mem_wr, d_wr_ack}), 16'd0);

    // Simultaneous fills alternate, starting with I after reset.
    apply_reset();
    i_req = 1'b1; i_addr = 16'h1000;
    d_req = 1'b1; d_addr = 16'h2000;
    fill_run(1'b1, 16'h1000, 11, -1);
    cyc();
    chk("pair_idle1", 16'(mem_enable), 16'd0);
    i_req = 1'b1; i_addr = 16'h1100;
    fill_run(1'b0, 16'h2000, 11, -1);
    cyc();
    d_req = 1'b1; d_addr = 16'h2100;
    fill_run(1'b1, 16'h1100, 11, -1);
    cyc();
    d_req = 1'b0;
    cyc();
    chk("pair_quiet", 16'(mem_enable), 16'd0);

    // Write arriving mid-fill waits for the fill to finish.
    i_req = 1'b1; i_addr = 16'h3000;
    fill_run(1'b1, 16'h3000, 11, 2);
    cyc();
    chk("wwait_idle", 16'({mem_enable, mem_wr}), 16'd0);
    chk("wwait_stall", 16'(d_stall), 16'd1);
    cyc();
    chk("wwait_wr", 16'({mem_enable, mem_wr, d_wr_ack}), 16'd7);
    chk("wwait_addr", mem_addr, 16'h0080);
    chk("wwait_data", mem_wdata, 16'h1234);
    d_req = 1'b0; d_wr = 1'b0;
    cyc();
    chk("wwait_after", 16'(d_wr_ack), 16'd0);

    // Reset while issuing word 3; stale returns must be discarded.
    i_req = 1'b1; i_addr = 16'h4000;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("abort_iss", mem_addr, 16'h4000 + 16'(2 * c));
    end
    rst = 1'b1;
    #1;
    chk("abort_en", 16'({mem_enable, mem_wr}), 16'd0);
    chk("abort_addr", mem_addr, 16'h0000);
    chk("abort_fill", 16'({i_fill_valid, i_done, d_fill_valid, d_wr_ack}), 16'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stale_drop", 16'({i_fill_valid, mem_enable}), 16'd0);
    end
    cyc();
    chk("abort_idle", 16'(mem_enable), 16'd0);
    fill_run(1'b1, 16'h4000, 11, -1);

    // Request dropped right after grant still completes, then stays quiet.
    cyc();
    i_req = 1'b1; i_addr = 16'h5000;
    fill_run(1'b1, 16'h5000, 0, -1);
    cyc();
    chk("drop_quiet1", 16'(mem_enable), 16'd0);
    cyc();
    chk("drop_quiet2", 16'({mem_enable, i_fill_valid}), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the pipelined I-cache/D-cache control, between its two fill paths and the single 4-cycle pipelined main memory.
- Arbitrates I-fill, D-fill and D write-through requests.
- Issues eight consecutive word reads per block fill and returns the words, tagged with word index, to the requesting cache.
- Signals fill completion and write acknowledge so the caches can release their stalls.

Parameters:
LATENCY, 4, memory read latency in cycles (enable to data_valid)
WORDS, 8, 16-bit words per cache block
ADDR_W, 16, byte address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_req  in  1  I-cache fill request; held until i_done
i_addr  in  16  I-cache miss address; bits [3:0] ignored
d_req  in  1  D-cache request (fill or write); held until d_done/d_wr_ack
d_wr  in  1  with d_req: 1 = single-word write-through, 0 = block fill
d_addr  in  16  D-cache address
d_wdata  in  16  write-through data
i_fill_valid  out  1  word for I-cache valid this cycle
i_fill_word  out  3  word index of i_fill_data
i_fill_data  out  16  fill data to I-cache
i_done  out  1  one-cycle pulse with last I fill word
i_stall  out  1  i_req & ~i_done
d_fill_valid  out  1  word for D-cache valid this cycle
d_fill_word  out  3  word index of d_fill_data
d_fill_data  out  16  fill data to D-cache
d_done  out  1  one-cycle pulse with last D fill word
d_wr_ack  out  1  one-cycle pulse when write issued to memory
d_stall  out  1  d_req & ~(d_done | d_wr_ack)
mem_enable  out  1  memory enable
mem_wr  out  1  memory write
mem_addr  out  16  memory byte address
mem_wdata  out  16  memory write data
mem_data_out  in  16  memory read data
mem_data_valid  in  1  memory read data valid

Behaviour:
- Reset: async, active-high. All state, counters, pulses and mem_* outputs go to 0. State is DRAIN with drain counter = LATENCY.
- States:
  - DRAIN: no grants; counts down LATENCY cycles so in-flight memory data is discarded; then IDLE.
  - IDLE: selects the next request.
  - WRITE: exactly one cycle; mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_wr_ack=1; then IDLE.
  - FILL_I / FILL_D: run a block fill for the granted cache.
- IDLE priority:
  - d_req&d_wr goes to WRITE first.
  - Among pending fills, grant the one not served last, using a registered last_fill bit (reset 0 = I favoured).
  - A lone fill request is granted immediately.
- Grant decision is registered: first memory read issues the cycle after the request is seen in IDLE.
- Fill, issue phase:
  - issue counter 0..7, mem_enable=1, mem_wr=0, mem_addr={addr[15:4], issue_cnt, 1'b0}.
  - Counter increments each cycle.
  - mem_enable drops after the word-7 issue (8 consecutive issue cycles).
- Fill, return phase:
  - Return counter increments on each mem_data_valid.
  - Granted cache gets fill_valid=mem_data_valid, fill_word=ret_cnt, fill_data=mem_data_out.
  - Ungranted cache fill outputs stay 0.
- Completion:
  - done pulses in the same cycle as the word-7 fill_valid.
  - Next state IDLE; last_fill updated.
  - Total fill = 8 + LATENCY cycles after grant (12 for default).
- mem_data_valid outside FILL states is ignored.
- Request dropped mid-fill: fill runs to completion (memory pipeline must drain); done still pulses.
- Writes never preempt a fill in progress; they wait in IDLE. Fills never start while WRITE is active.
- Reset mid-fill: immediate abort, all outputs 0, DRAIN entered.
- Counters are 3-bit and wrap 7→0 naturally; wrap is used only at block end.

Decomposition:
- Shared package cache_pkg:
  - WORDS, LATENCY, state enum (DRAIN, IDLE, WRITE, FILL_I, FILL_D).
  - Word-offset helper: block base = addr[15:4].
- One sub-module, arb_fill_seq:
  - Issue and return counters, done generation.
  - Inputs: start, mem_data_valid. Outputs: issue_active, issue_cnt, ret_cnt, last_word.
  - Instantiated once.
  - The top holds arbitration, the drain counter and output muxing.

Test Plan:
- Reset, then i_req, i_addr=16'h1234 → DRAIN 4 cycles. mem_addr 16'h1230,1232,…,123E on 8 consecutive cycles. i_fill_word 0..7 with data; i_done on word 7, 12 cycles after grant.
- d_req&d_wr, d_addr=16'h0040, d_wdata=16'hBEEF in IDLE → one cycle mem_wr=1, mem_addr=16'h0040, mem_wdata=16'hBEEF, d_wr_ack=1.
- i_req and d_req (fill) asserted together twice in a row → first grant I (last_fill reset 0), then D. Next simultaneous pair grants I again.
- D write arrives during an I fill → no memory write until i_done. WRITE occurs the cycle after return to IDLE.
- rst asserted at issue word 3 of a fill → all outputs 0 immediately. Stale mem_data_valid during DRAIN produces no fill_valid. Re-request completes with 8 clean words.
- i_req deasserted after grant → 8 reads still issued; i_done pulses; no extra fill starts.
